inst_fetch_responder: RTL and testbench

Memory-side responder for the instruction-fetch request/response protocol. Accepts word fetches from the pre-IF stage with an `addr_ok` handshake and issues them as reads on a simple AR/R memory channel. It returns in-order single-cycle `icache_data_ok` pulses with `icache_rdata` to the fetch stage. Sits between the pre-IF/IF stages and the instruction memory port, in the slot later occupied by a full I-cache.

---
 rtl/inst_fetch_responder.sv | 164 ++++++++++++++++
 tb/tb_inst_fetch_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: memory-side responder for instruction fetch.
// Accepts word fetches with an addr_ok handshake and issues them as AR/R
// memory reads. Every accepted fetch returns one in-order data_ok pulse.
// Optional one-entry hit buffer enabled by defining INST_FETCH_HIT_BUF_EN.
module inst_fetch_responder #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic        icache_addr_ok,
    output logic        icache_data_ok,
    output logic [31:0] icache_rdata,
    input  logic        icache_inv,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_rready
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_t;

    ar_state_t   state;
    logic [CW-1:0] cnt;
    logic        mem_accept;
    logic        hit;
    logic        rsp;
    logic [31:0] buf_word;

    assign mem_rready = 1'b1;

    // A read response with nothing outstanding is a protocol error and is dropped.
    assign rsp = mem_rvalid && (cnt != '0);

`ifdef INST_FETCH_HIT_BUF_EN
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:2] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic        buf_valid;
    logic [31:2] buf_addr;
    logic [31:0] buf_data;
    logic        unused_bits;

    assign unused_bits = &{1'b0, icache_addr[1:0]};

    // Hit only when the memory path is fully quiet so ordering is trivially kept.
    always_comb begin
        hit = icache_req && buf_valid && (icache_addr[31:2] == buf_addr) &&
              (cnt == '0) && (state == AR_IDLE) && !mem_rvalid && !icache_inv;
    end

    assign buf_word = buf_data;

    // Address FIFO storage: word address pushed on each memory-path accept.
    always_ff @(posedge clk) begin
        if (mem_accept) begin
            fifo_mem[wr_ptr] <= icache_addr[31:2];
        end
    end

    // FIFO pointers and hit buffer capture of each returning response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            if (mem_accept) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rsp) begin
                rd_ptr    <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
                buf_addr  <= fifo_mem[rd_ptr];
                buf_data  <= mem_rdata;
                buf_valid <= !icache_inv;
            end else if (icache_inv) begin
                buf_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits = &{1'b0, icache_addr[1:0], icache_inv};
    assign hit         = 1'b0;
    assign buf_word    = '0;
`endif

    // Request acceptance: buffer hit or a free memory-path slot.
    always_comb begin
        mem_accept     = icache_req && (state == AR_IDLE) && (cnt < MAX_CNT) && !hit;
        icache_addr_ok = mem_accept || hit;
    end

    // AR channel state machine with registered arvalid/araddr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= AR_IDLE;
            mem_arvalid <= 1'b0;
            mem_araddr  <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (mem_accept) begin
                        mem_araddr  <= icache_addr & 32'hFFFF_FFFC;
                        mem_arvalid <= 1'b1;
                        state       <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        state       <= AR_IDLE;
                    end
                end
                default: begin
                    mem_arvalid <= 1'b0;
                    state       <= AR_IDLE;
                end
            endcase
        end
    end

    // Outstanding read counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (mem_accept && !rsp) begin
            cnt <= cnt + CW'(1);
        end else if (rsp && !mem_accept) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Registered response to the fetch stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icache_data_ok <= 1'b0;
            icache_rdata   <= '0;
        end else begin
            icache_data_ok <= rsp || hit;
            if (rsp) begin
                icache_rdata <= mem_rdata;
            end else if (hit) begin
                icache_rdata <= buf_word;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with a scoreboard queue of
// expected instruction words popped by a monitor on every data_ok pulse.
module tb_inst_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata;
    logic        icache_inv;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    inst_fetch_responder #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata   (icache_rdata),
        .icache_inv     (icache_inv),
        .mem_arvalid    (mem_arvalid),
        .mem_araddr     (mem_araddr),
        .mem_arready    (mem_arready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_rready     (mem_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every data_ok pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (icache_data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                chk("sb_rdata", icache_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inv();
        icache_inv = 1'b1;
        step();
        icache_inv = 1'b0;
    endtask

    task automatic single_fetch(input logic [31:0] a, input logic [31:0] d);
        icache_req  = 1'b1;
        icache_addr = a;
        mem_arready = 1'b1;
        #2;
        chk("sf_addr_ok", icache_addr_ok, 1);
        step();
        icache_req = 1'b0;
        #2;
        chk("sf_arvalid", mem_arvalid, 1);
        chk("sf_araddr", mem_araddr, a & 32'hFFFF_FFFC);
        step();
        #2;
        chk("sf_arvalid_drop", mem_arvalid, 0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        exp_q.push_back(d);
        #2;
        chk("sf_data_ok_early", icache_data_ok, 0);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("sf_data_ok", icache_data_ok, 1);
        chk("sf_rdata", icache_rdata, d);
        step();
        #2;
        chk("sf_data_ok_pulse", icache_data_ok, 0);
        chk("sf_cnt_zero", 32'(dut.cnt), 0);
    endtask

    initial begin
        reset       = 1'b1;
        icache_req  = 1'b0;
        icache_addr = '0;
        icache_inv  = 1'b0;
        mem_arready = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        step();
        step();
        chk("rst_data_ok", icache_data_ok, 0);
        chk("rst_rdata", icache_rdata, 0);
        chk("rst_arvalid", mem_arvalid, 0);
        chk("rst_araddr", mem_araddr, 0);
        chk("rst_rready", mem_rready, 1);
        #2;
        reset = 1'b0;
        step();

        // Single fetch
        single_fetch(32'hBFC0_0000, 32'h2402_000A);

        // Back-to-back fetches, responses stalled until cnt saturates
        pulse_inv();
        icache_req  = 1'b1;
        icache_addr = 32'hBFC0_0000;
        #2;
        chk("b2b_ok0", icache_addr_ok, 1);
        step();
        icache_addr = 32'hBFC0_0004;
        #2;
        chk("b2b_busy_block", icache_addr_ok, 0);
        step();
        #2;
        chk("b2b_ok1", icache_addr_ok, 1);
        step();
        icache_addr = 32'hBFC0_0008;
        #2;
        chk("b2b_araddr1", mem_araddr, 32'hBFC0_0004);
        chk("b2b_busy_block2", icache_addr_ok, 0);
        step();
        #2;
        chk("b2b_cnt_two", 32'(dut.cnt), 2);
        chk("b2b_full_block", icache_addr_ok, 0);
        step();
        #2;
        chk("b2b_full_block2", icache_addr_ok, 0);
        icache_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        exp_q.push_back(32'h1111_1111);
        step();
        mem_rdata = 32'h2222_2222;
        exp_q.push_back(32'h2222_2222);
        #2;
        chk("b2b_first_rdata", icache_rdata, 32'h1111_1111);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("b2b_second_data_ok", icache_data_ok, 1);
        step();
        #2;
        chk("b2b_cnt_zero", 32'(dut.cnt), 0);

        // AR stall: arvalid/araddr hold, no further acceptance
        icache_req  = 1'b1;
        icache_addr = 32'hBFC0_0010;
        mem_arready = 1'b0;
        #2;
        chk("stall_ok", icache_addr_ok, 1);
        step();
        icache_addr = 32'hBFC0_0014;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_arvalid", mem_arvalid, 1);
            chk("stall_araddr", mem_araddr, 32'hBFC0_0010);
            chk("stall_addr_ok", icache_addr_ok, 0);
            step();
        end
        icache_req  = 1'b0;
        mem_arready = 1'b1;
        step();
        #2;
        chk("stall_release", mem_arvalid, 0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_3333;
        exp_q.push_back(32'h3333_3333);
        step();
        mem_rvalid = 1'b0;
        #2;
        chk("stall_data_ok", icache_data_ok, 1);
        step();

`ifdef INST_FETCH_HIT_BUF_EN
        // Hit buffer: repeat fetch served locally, invalidate forces memory read
        single_fetch(32'h8000_1000, 32'hA5A5_0001);
        icache_req  = 1'b1;
        icache_addr = 32'h8000_1000;
        #2;
        chk("hit_addr_ok", icache_addr_ok, 1);
        exp_q.push_back(32'hA5A5_0001);
        step();
        icache_req = 1'b0;
        #2;
        chk("hit_no_arvalid", mem_arvalid, 0);
        chk("hit_data_ok", icache_data_ok, 1);
        chk("hit_rdata", icache_rdata, 32'hA5A5_0001);
        step();
        pulse_inv();
        single_fetch(32'h8000_1000, 32'hA5A5_0002);
`endif

        // Asynchronous reset while a read is outstanding
        icache_req  = 1'b1;
        icache_addr = 32'hBFC0_0020;
        mem_arready = 1'b0;
        step();
        icache_req = 1'b0;
        #2;
        chk("mid_arvalid", mem_arvalid, 1);
        chk("mid_cnt", 32'(dut.cnt), 1);
        reset = 1'b1;
        #1;
        chk("arst_arvalid", mem_arvalid, 0);
        chk("arst_araddr", mem_araddr, 0);
        chk("arst_data_ok", icache_data_ok, 0);
        chk("arst_rdata", icache_rdata, 0);
        chk("arst_cnt", 32'(dut.cnt), 0);
        step();
        reset = 1'b0;
        step();
        single_fetch(32'hBFC0_0022, 32'h0C00_0123);

        step();
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
